// File: rtl/read_word_packer_if.sv
// FIFO read port plus packed-word valid/ready output, shared by the packer and its environment.
interface read_word_packer_if #(
  parameter int unsigned data_size  = 8,
  parameter int unsigned pack_count = 4
);
  localparam int unsigned bytes_w = $clog2(pack_count + 1);

  logic                             read_empty;
  logic [data_size-1:0]             read_data;
  logic                             read_incr;
  logic [data_size*pack_count-1:0]  out_data;
  logic [bytes_w-1:0]               out_bytes;
  logic                             out_valid;
  logic                             out_ready;

  modport master (
    input  read_empty, read_data, out_ready,
    output read_incr, out_data, out_bytes, out_valid
  );

  modport slave (
    output read_empty, read_data, out_ready,
    input  read_incr, out_data, out_bytes, out_valid
  );
endinterface

// File: rtl/read_word_packer.sv
// Packs pack_count FIFO entries into one output word, with explicit flush of partial words.
// Optional macro FLUSH_TIMEOUT_EN adds an idle-timeout auto-flush after timeout_cycles.
module read_word_packer #(
  parameter int unsigned data_size      = 8,
  parameter int unsigned pack_count     = 4,
  parameter int unsigned timeout_cycles = 16
) (
  input  logic                  read_clk,
  input  logic                  rreset,
  read_word_packer_if.master    bus,
  input  logic                  flush_req,
  output logic                  busy
);
  localparam int unsigned lane_w  = $clog2(pack_count);
  localparam int unsigned bytes_w = $clog2(pack_count + 1);
  localparam int unsigned acc_w   = data_size * (pack_count - 1);

  if (pack_count < 2 || timeout_cycles < 1) begin : g_param_check
    $error("read_word_packer: pack_count must be >= 2 and timeout_cycles >= 1");
  end

  typedef enum logic {FILL, FLUSH_PEND} state_t;

  state_t                          state, state_next;
  logic [acc_w-1:0]                acc;
  logic [lane_w-1:0]               lane_cnt;
  logic [data_size*pack_count-1:0] out_data_q;
  logic [bytes_w-1:0]              out_bytes_q;
  logic                            out_valid_q;
  logic                            out_free;
  logic                            last_lane;
  logic                            pop;
  logic                            flush_trig;
  logic                            timeout_hit;
  logic                            emit_partial;

  assign out_free     = !out_valid_q || bus.out_ready;
  assign last_lane    = (lane_cnt == lane_w'(pack_count - 1));
  assign flush_trig   = flush_req || timeout_hit;
  assign emit_partial = (state == FLUSH_PEND) && out_free && (lane_cnt != '0);

  assign bus.out_data  = out_data_q;
  assign bus.out_bytes = out_bytes_q;
  assign bus.out_valid = out_valid_q;
  assign bus.read_incr = pop;

  always_ff @(posedge read_clk or posedge rreset) begin
    if (rreset) state <= FILL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:       if (flush_trig) state_next = FLUSH_PEND;
      FLUSH_PEND: if (out_free)   state_next = FILL;
      default:    state_next = FILL;
    endcase
  end

  // The last lane is only popped when the output register can take the finished word.
  always_comb begin
    pop  = 1'b0;
    if (!rreset && state == FILL)
      pop = !bus.read_empty && (!last_lane || out_free);
    busy = (lane_cnt != '0) || (state == FLUSH_PEND) || out_valid_q;
  end

  // Accumulator only holds lanes 0..pack_count-2; the final lane goes straight to the output.
  always_ff @(posedge read_clk or posedge rreset) begin
    if (rreset) begin
      acc         <= '0;
      lane_cnt    <= '0;
      out_data_q  <= '0;
      out_bytes_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;
      if (pop && last_lane) begin
        out_data_q  <= {bus.read_data, acc};
        out_bytes_q <= bytes_w'(pack_count);
        out_valid_q <= 1'b1;
        acc         <= '0;
        lane_cnt    <= '0;
      end else if (pop) begin
        for (int unsigned i = 0; i < pack_count - 1; i++)
          if (lane_cnt == lane_w'(i))
            acc[i*data_size +: data_size] <= bus.read_data;
        lane_cnt <= lane_cnt + lane_w'(1);
      end else if (emit_partial) begin
        out_data_q  <= {{data_size{1'b0}}, acc};
        out_bytes_q <= bytes_w'(lane_cnt);
        out_valid_q <= 1'b1;
        acc         <= '0;
        lane_cnt    <= '0;
      end
    end
  end

`ifdef FLUSH_TIMEOUT_EN
  localparam int unsigned idle_w = $clog2(timeout_cycles + 1);
  logic [idle_w-1:0] idle_cnt;

  assign timeout_hit = (state == FILL) && (idle_cnt == idle_w'(timeout_cycles));

  always_ff @(posedge read_clk or posedge rreset) begin
    if (rreset)
      idle_cnt <= '0;
    else if (pop || lane_cnt == '0 || timeout_hit)
      idle_cnt <= '0;
    else if (state == FILL)
      idle_cnt <= idle_cnt + idle_w'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif
endmodule

// File: tb/tb_read_word_packer.sv
// Randomized bench for read_word_packer against a queue-based packing model.
module tb_read_word_packer;
  localparam int unsigned DW = 8;
  localparam int unsigned PC = 4;
  localparam int unsigned TO = 16;

  logic read_clk = 1'b0;
  logic rreset;
  logic flush_req;
  logic busy;

  read_word_packer_if #(.data_size(DW), .pack_count(PC)) bus();

  read_word_packer #(.data_size(DW), .pack_count(PC), .timeout_cycles(TO)) dut (
    .read_clk  (read_clk),
    .rreset    (rreset),
    .bus       (bus),
    .flush_req (flush_req),
    .busy      (busy)
  );

  always #5 read_clk = ~read_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo[$];
  logic [7:0]  pend[$];
  logic [31:0] exp_data[$];
  logic [2:0]  exp_bytes[$];

  int beats = 0, pops = 0, cyc = 0, vcount = 0, since_pop = 0;
  int last_beat_cyc = 0, prev_beat_cyc = 0;
  logic [31:0] last_data = '0;
  logic [2:0]  last_bytes = '0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic [2:0]  prev_bytes = '0;

  int beats0, pops0, w, pop_cyc, force_ready, cool;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_emit();
    logic [31:0] word;
    word = '0;
    if (pend.size() == 0) return;
    foreach (pend[i]) word[i*8 +: 8] = pend[i];
    exp_data.push_back(word);
    exp_bytes.push_back(3'(pend.size()));
    pend.delete();
  endtask

  task automatic refresh_fifo();
    bus.read_empty = (fifo.size() == 0);
    bus.read_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] v);
    fifo.push_back(v);
    refresh_fifo();
  endtask

  task automatic model_reset();
    pend.delete();
    exp_data.delete();
    exp_bytes.delete();
    prev_hold = 1'b0;
  endtask

  task automatic tick();
    logic pop, hs;
    @(negedge read_clk);
    cyc++;
    pop = bus.read_incr;
    hs  = bus.out_valid & bus.out_ready;
    if (bus.out_valid) vcount++;
    if (pop) check("pop_not_empty", fifo.size() != 0, 1);
    if (prev_hold) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, prev_data);
      check("hold_bytes", bus.out_bytes, prev_bytes);
    end
    if (hs) begin
      beats++;
      prev_beat_cyc = last_beat_cyc;
      last_beat_cyc = cyc;
      last_data  = bus.out_data;
      last_bytes = bus.out_bytes;
      check("beat_expected", exp_data.size() != 0, 1);
      if (exp_data.size() != 0) begin
        check("beat_data", bus.out_data, exp_data.pop_front());
        check("beat_bytes", bus.out_bytes, exp_bytes.pop_front());
      end
    end
    if (pop && fifo.size() != 0) begin
      pend.push_back(fifo[0]);
      pops++;
      since_pop = 0;
      if (pend.size() == PC) model_emit();
    end else begin
      since_pop++;
    end
    if (flush_req && !rreset) model_emit();
    prev_hold  = bus.out_valid & !bus.out_ready;
    prev_data  = bus.out_data;
    prev_bytes = bus.out_bytes;
    @(posedge read_clk);
    #1;
    if (pop && fifo.size() != 0) void'(fifo.pop_front());
    refresh_fifo();
  endtask

  initial begin
    rreset = 1'b1;
    flush_req = 1'b0;
    bus.out_ready = 1'b1;
    refresh_fifo();

    // Reset state, with entries waiting that must not be popped
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(); tick();
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_bytes", bus.out_bytes, 0);
    check("rst_busy", busy, 0);
    check("rst_incr", bus.read_incr, 0);

    // Test 1: one full word
    rreset = 1'b0;
    pops0 = pops; beats0 = beats; vcount = 0;
    repeat (10) tick();
    check("t1_pops", pops - pops0, 4);
    check("t1_beats", beats - beats0, 1);
    check("t1_valid_cycles", vcount, 1);
    check("t1_data", last_data, 32'h44332211);
    check("t1_bytes", last_bytes, 4);

    // Test 2: backpressure holds the last lane in the FIFO
    bus.out_ready = 1'b0;
    pops0 = pops; beats0 = beats;
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    repeat (12) tick();
    check("t2_pops", pops - pops0, 7);
    check("t2_fifo_left", fifo.size(), 1);
    check("t2_incr_low", bus.read_incr, 0);
    check("t2_held_data", bus.out_data, 32'h44332211);
    check("t2_held_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    repeat (6) tick();
    check("t2_beats", beats - beats0, 2);
    check("t2_data2", last_data, 32'h88776655);
    check("t2_back_to_back", last_beat_cyc - prev_beat_cyc, 1);

    // Test 3: flush of a two-lane partial word
    push(8'hA1); push(8'hB2);
    repeat (3) tick();
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    repeat (4) tick();
    check("t3_data", last_data, 32'h0000B2A1);
    check("t3_bytes", last_bytes, 2);
    check("t3_busy", busy, 0);

    // Test 4: flush with nothing accumulated
    beats0 = beats;
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    check("t4_pend_busy", busy, 1);
    tick();
    check("t4_back_to_fill", busy, 0);
    repeat (3) tick();
    check("t4_no_beat", beats - beats0, 0);

    // Test 5: reset mid-word with a pending output word
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i * 8'h11));
    repeat (8) tick();
    push(8'h77);
    #1;
    check("t5_incr_before", bus.read_incr, 1);
    rreset = 1'b1;
    #1;
    check("t5_valid", bus.out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_incr", bus.read_incr, 0);
    model_reset();
    tick(); tick();
    rreset = 1'b0;
    bus.out_ready = 1'b1;
    push(8'h01); push(8'h02); push(8'h03);
    repeat (8) tick();
    check("t5_clean_data", last_data, 32'h03020177);
    check("t5_clean_bytes", last_bytes, 4);

    // Test 6: idle timeout behaviour
    beats0 = beats;
    push(8'h5A);
    tick();
    pop_cyc = cyc;
`ifdef FLUSH_TIMEOUT_EN
    model_emit();
    w = 0;
    while (beats == beats0 && w < 40) begin tick(); w++; end
    check("t6_beat_seen", beats - beats0, 1);
    check("t6_data", last_data, 32'h0000005A);
    check("t6_bytes", last_bytes, 1);
    check("t6_latency", (last_beat_cyc - pop_cyc) >= 17 && (last_beat_cyc - pop_cyc) <= 20, 1);
`else
    repeat (40) tick();
    check("t6_no_auto_flush", beats - beats0, 0);
    check("t6_partial_busy", busy, 1);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    repeat (4) tick();
    check("t6_manual_data", last_data, 32'h0000005A);
    check("t6_manual_bytes", last_bytes, 1);
`endif

    // Randomized traffic with occasional flushes
    force_ready = 0; cool = 0;
    for (int n = 0; n < 800; n++) begin
      flush_req = 1'b0;
      if (force_ready > 0) begin
        bus.out_ready = 1'b1;
        force_ready--;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 9) < 6) push(8'($urandom));
      if (since_pop >= 8) begin
        bus.out_ready = 1'b1;
        if (fifo.size() == 0) push(8'($urandom));
      end
      if (cool > 0) cool--;
      else if ($urandom_range(0, 19) == 0) begin
        flush_req = 1'b1;
        force_ready = 2;
        cool = 4;
      end
      tick();
    end

    // Drain everything, then flush the remainder
    flush_req = 1'b0;
    bus.out_ready = 1'b1;
    w = 0;
    while ((fifo.size() != 0 || exp_data.size() != 0) && w < 200) begin tick(); w++; end
    check("drain_in_time", w < 200, 1);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    repeat (6) tick();
    check("final_exp_empty", exp_data.size(), 0);
    check("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
